// File: rtl/pixel_scanout.sv
// pixel_scanout: 3-bit framebuffer write port plus VGA scan-out.
//
// The framebuffer holds (H_VISIBLE >> SCALE_LOG2) x (V_VISIBLE >> SCALE_LOG2)
// pixels, which is 160x120 at the default 640x480 timing. Each stored pixel
// is shown as a (1 << SCALE_LOG2)-square block. The pixel clock is clock/2.
// Scan position decodes to a read address in cycle c. The memory data is valid
// in c+1, and RGB and the syncs are registered in c+2.
//
// Build option PIXEL_SCANOUT_CLIP_EN:
//   defined   - writes with x or y outside the framebuffer are dropped and
//               pulse `clipped` for one clock.
//   undefined - the address is formed from raw x/y. A linear address past the
//               end of the framebuffer is dropped silently. `clipped` stays 0.
//
// Porch and sync widths are parameters. They default to 640x480@60 timing.
module pixel_scanout #(
    parameter int H_VISIBLE  = 640,
    parameter int V_VISIBLE  = 480,
    parameter int SCALE_LOG2 = 2,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic       frame_start,
    output logic       clipped,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int FB_W    = H_VISIBLE >> SCALE_LOG2;
    localparam int FB_H    = V_VISIBLE >> SCALE_LOG2;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int AW      = $clog2(FB_SIZE);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_LAST = VW'(V_VISIBLE - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          wr_clip;

`ifdef PIXEL_SCANOUT_CLIP_EN
    assign wr_clip = plot && ((32'(x) >= 32'(FB_W)) || (32'(y) >= 32'(FB_H)));
    assign wr_en   = plot && !wr_clip;
    assign wr_addr = AW'(32'(y) * 32'(FB_W) + 32'(x));
`else
    // A raw x past the row end aliases into the next row. Only addresses
    // beyond the whole buffer are discarded.
    logic [31:0] wr_lin;
    assign wr_lin  = 32'(y) * 32'(FB_W) + 32'(x);
    assign wr_clip = 1'b0;
    assign wr_en   = plot && (wr_lin < 32'(FB_SIZE));
    assign wr_addr = AW'(wr_lin);
`endif

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic          pix_en;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;

    // Pixel-rate enable and raster position; one position per two clocks.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            pix_en <= 1'b0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (hcount == H_LAST) begin
                    hcount <= '0;
                    vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
                end else begin
                    hcount <= hcount + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Region decode (pipeline stage 0)
    // ------------------------------------------------------------------
    logic          visible;
    logic          hs_n;
    logic          vs_n;
    logic          fs_next;
    logic [AW-1:0] rd_addr;

    assign visible = (hcount < H_VIS_END) && (vcount < V_VIS_END);
    assign hs_n    = !((hcount >= H_SYNC_BEG) && (hcount < H_SYNC_END));
    assign vs_n    = !((vcount >= V_SYNC_BEG) && (vcount < V_SYNC_END));
    assign rd_addr = visible
                   ? AW'(32'(vcount >> SCALE_LOG2) * 32'(FB_W) + 32'(hcount >> SCALE_LOG2))
                   : '0;
    // The tick fires on the step that moves vcount into the front porch.
    assign fs_next = pix_en && (hcount == H_LAST) && (vcount == V_VIS_LAST);

    // ------------------------------------------------------------------
    // Framebuffer (stage 1): the read sees contents from before a same-cycle write
    // ------------------------------------------------------------------
    logic [2:0] fb_mem [FB_SIZE];
    logic [2:0] rd_data;

    // Single write port from the game side, single read port for scan-out.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            fb_mem[wr_addr] <= colour;
        end
        rd_data <= fb_mem[rd_addr];
    end

    // ------------------------------------------------------------------
    // Stage 1 control delay, matched to the memory read
    // ------------------------------------------------------------------
    logic vis_d1;
    logic hs_d1;
    logic vs_d1;

    // Delay sync/blank decode by one clock so it lines up with rd_data.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            vis_d1 <= 1'b0;
            hs_d1  <= 1'b1;
            vs_d1  <= 1'b1;
        end else begin
            vis_d1 <= visible;
            hs_d1  <= hs_n;
            vs_d1  <= vs_n;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 output registers
    // ------------------------------------------------------------------
    // Register every pin-facing output. RGB is forced to zero outside the visible area.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            VGA_CLK     <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            frame_start <= 1'b0;
            clipped     <= 1'b0;
        end else begin
            VGA_CLK     <= pix_en;
            VGA_HS      <= hs_d1;
            VGA_VS      <= vs_d1;
            VGA_BLANK_N <= vis_d1;
            VGA_R       <= {10{rd_data[2] & vis_d1}};
            VGA_G       <= {10{rd_data[1] & vis_d1}};
            VGA_B       <= {10{rd_data[0] & vis_d1}};
            frame_start <= fs_next;
            clipped     <= wr_clip;
        end
    end

    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_pixel_scanout.sv
// Testbench for pixel_scanout.
// The main instance uses a shrunken raster: 64x48 visible, a 16x12 framebuffer,
// and 8800 clocks per frame. A frame-position model checks it on every clock.
// A second instance uses the default 640x480 timing and has its line timing
// pinned with literal values.
`timescale 1ns/1ps
module tb_pixel_scanout;

    localparam int HV = 64, HFP = 4, HSY = 8, HBP = 4, HT = 80;
    localparam int VV = 48, VFP = 2, VSY = 2, VBP = 3, VT = 55;
    localparam int FBW = 16, FBH = 12, FBN = 192;
    localparam int FRAME = 2 * HT * VT;

`ifdef PIXEL_SCANOUT_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic [7:0] x      = '0;
    logic [6:0] y      = '0;
    logic [2:0] colour = '0;
    logic       plot   = 1'b0;

    logic       fs, clip, vclk, hs, vs, blank, sync_n;
    logic [9:0] r, g, b;
    logic       f_fs, f_clip, f_vclk, f_hs, f_vs, f_blank, f_sync_n;
    logic [9:0] f_r, f_g, f_b;

    pixel_scanout #(
        .H_VISIBLE(HV), .V_VISIBLE(VV), .SCALE_LOG2(2),
        .H_FRONT(HFP), .H_SYNC(HSY), .H_BACK(HBP),
        .V_FRONT(VFP), .V_SYNC(VSY), .V_BACK(VBP)
    ) dut (
        .clock(clock), .resetn(rst), .x(x), .y(y), .colour(colour), .plot(plot),
        .frame_start(fs), .clipped(clip), .VGA_CLK(vclk), .VGA_HS(hs), .VGA_VS(vs),
        .VGA_BLANK_N(blank), .VGA_SYNC_N(sync_n), .VGA_R(r), .VGA_G(g), .VGA_B(b)
    );

    pixel_scanout dut_full (
        .clock(clock), .resetn(rst), .x(x), .y(y), .colour(colour), .plot(plot),
        .frame_start(f_fs), .clipped(f_clip), .VGA_CLK(f_vclk), .VGA_HS(f_hs), .VGA_VS(f_vs),
        .VGA_BLANK_N(f_blank), .VGA_SYNC_N(f_sync_n), .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0d expected %0d (clock %0d)", name, act, exp, n);
        end
    endtask

    // clocks since reset release; the value after edge k is k
    always @(posedge clock) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    // ---------------- behavioural model ----------------
    int fb[FBN];
    bit exp_clip = 1'b0;

    initial begin
        foreach (fb[i]) fb[i] = -1;
    end

    always @(posedge clock) begin
        int a;
        exp_clip = 1'b0;
        if (!rst && plot) begin
            if (CLIP) begin
                if (int'(x) < FBW && int'(y) < FBH) fb[int'(y) * FBW + int'(x)] = int'(colour);
                else exp_clip = 1'b1;
            end else begin
                a = int'(y) * FBW + int'(x);
                if (a < FBN) fb[a] = int'(colour);
            end
        end
    end

    typedef struct {
        bit hs;
        bit vs;
        bit blank;
        int col;
    } exp_t;

    // Screen state for raster position k clocks after release.
    // The pins show it two clocks later.
    function automatic exp_t model_at(input int k);
        exp_t e;
        int p, h, v;
        p = k / 2;
        h = p % HT;
        v = (p / HT) % VT;
        e.blank = (h < HV) && (v < VV);
        e.hs    = !(h >= HV + HFP && h < HV + HFP + HSY);
        e.vs    = !(v >= VV + VFP && v < VV + VFP + VSY);
        e.col   = e.blank ? fb[(v / 4) * FBW + (h / 4)] : 0;
        return e;
    endfunction

    function automatic int rgb_word(input int c);
        int w;
        w = 0;
        if ((c & 4) != 0) w = w | (32'h3FF << 20);
        if ((c & 2) != 0) w = w | (32'h3FF << 10);
        if ((c & 1) != 0) w = w | 32'h3FF;
        return w;
    endfunction

    exp_t e1, e2, erst;

    initial begin
        erst.hs = 1'b1; erst.vs = 1'b1; erst.blank = 1'b0; erst.col = 0;
        e1 = erst; e2 = erst;
    end

    // compare every clock
    always @(negedge clock) begin
        int rgb_act;
        rgb_act = int'({2'b00, r, g, b});
        if (rst || n == 0) begin
            chk("rst_ctrl", int'({hs, vs, blank, vclk, fs, clip}), 6'b110000);
            chk("rst_rgb", rgb_act, 0);
            chk("rst_full_ctrl", int'({f_hs, f_vs, f_blank, f_vclk, f_fs, f_clip}), 6'b110000);
            e1 = model_at(0);
            e2 = erst;
        end else begin
            chk("hs", int'(hs), int'(e2.hs));
            chk("vs", int'(vs), int'(e2.vs));
            chk("blank_n", int'(blank), int'(e2.blank));
            if (e2.col >= 0) chk("rgb", rgb_act, rgb_word(e2.col));
            chk("vga_clk", int'(vclk), int'(n % 2 == 0));
            chk("frame_start", int'(fs), int'(n % FRAME == 2 * VV * HT));
            chk("clipped", int'(clip), int'(exp_clip));
            e2 = e1;
            e1 = model_at(n);
        end
        chk("sync_n", int'(sync_n), 0);
    end

    // ---------------- event capture for literal timing checks ----------------
    int fs_q[$], vsf_q[$], vsr_q[$], fhsf_q[$], fhsr_q[$], fblk_q[$];
    logic p_vs = 1'b1, p_fhs = 1'b1, p_fblk = 1'b0;

    always @(negedge clock) begin
        if (!rst && n > 0) begin
            if (fs) fs_q.push_back(n);
            if (p_vs && !vs) vsf_q.push_back(n);
            if (!p_vs && vs) vsr_q.push_back(n);
            if (p_fhs && !f_hs) fhsf_q.push_back(n);
            if (!p_fhs && f_hs) fhsr_q.push_back(n);
            if (!p_fblk && f_blank) fblk_q.push_back(n);
        end
        p_vs = vs; p_fhs = f_hs; p_fblk = f_blank;
    end

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic at(input int t);
        int guard;
        guard = 0;
        while (n < t && guard < 40000) begin
            @(posedge clock); #2;
            guard++;
        end
        chk("wait_reached", n, t);
    endtask

    task automatic plot_px(input int px, input int py, input int c);
        x = 8'(px); y = 7'(py); colour = 3'(c); plot = 1'b1;
        @(posedge clock); #2;
        plot = 1'b0;
    endtask

    initial begin
        #(600000 * 10);
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst = 1'b1;
        repeat (5) @(posedge clock);
        #2 rst = 1'b0;

        // fill the framebuffer with a known pattern
        for (int yy = 0; yy < FBH; yy++)
            for (int xx = 0; xx < FBW; xx++)
                plot_px(xx, yy, (xx + yy) % 8);

        plot_px(0, 0, 6);
        plot_px(15, 11, 3);

        // out-of-range column: aliases to (10,1) or is clipped
        x = 8'd26; y = 7'd0; colour = 3'b111; plot = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("clip_pulse", int'(clip), int'(CLIP));
        plot = 1'b0;
        @(negedge clock);
        chk("clip_one_clock", int'(clip), 0);
        @(posedge clock); #2;

        // address beyond the buffer: always dropped
        plot_px(200, 11, 5);

        // next frame: literal pixel checks
        at(FRAME + 10);
        chk("px40_r", int'(r), 0);
        chk("px40_b", int'(b), 10'h3FF);
        at(FRAME + 328);
        chk("px32_r", int'(r), 10'h3FF);
        chk("px32_g", int'(g), 10'h3FF);
        chk("px32_b", int'(b), 0);
        at(FRAME + 722);
        chk("alias_r", int'(r), CLIP ? 0 : 10'h3FF);
        chk("alias_g", int'(g), 10'h3FF);

        // collision: write the address being read at the same edge
        at(FRAME + 1807);
        x = 8'd5; y = 7'd2; colour = 3'b001; plot = 1'b1;
        @(posedge clock); #2;
        plot = 1'b0;
        @(posedge clock); #2;
        chk("collide_old_r", int'(r), 10'h3FF);
        chk("collide_old_b", int'(b), 10'h3FF);

        at(FRAME + 7648);
        chk("corner_r", int'(r), 0);
        chk("corner_gb", int'({g, b}), 20'hFFFFF);
        at(FRAME + 7650);
        chk("corner_right_blank", int'(blank), 0);
        chk("corner_right_g", int'(g), 0);

        at(2 * FRAME + 1809);
        chk("collide_new_r", int'(r), 0);
        chk("collide_new_b", int'(b), 10'h3FF);

        // two full frames of sync timing
        at(2 * FRAME + 20 * 2 * HT);
        chk("fs_count", fs_q.size(), 2);
        chk("fs_first", qat(fs_q, 0), 7680);
        chk("fs_period", qat(fs_q, 1) - qat(fs_q, 0), 8800);
        chk("vs_first_fall", qat(vsf_q, 0), 8002);
        chk("vs_low_width", qat(vsr_q, 0) - qat(vsf_q, 0), 320);
        chk("vs_period", qat(vsf_q, 1) - qat(vsf_q, 0), 8800);
        chk("full_hs_first_fall", qat(fhsf_q, 0), 2 * 656 + 2);
        chk("full_hs_low_width", qat(fhsr_q, 0) - qat(fhsf_q, 0), 192);
        chk("full_hs_period", qat(fhsf_q, 1) - qat(fhsf_q, 0), 1600);
        chk("full_blank_first", qat(fblk_q, 0), 2);

        // mid-frame reset at line 20
        rst = 1'b1;
        fs_q.delete(); vsf_q.delete(); vsr_q.delete();
        fhsf_q.delete(); fhsr_q.delete(); fblk_q.delete();
        repeat (3) @(posedge clock);
        #2 rst = 1'b0;
        at(8100);
        chk("restart_vs_fall", qat(vsf_q, 0), 8002);
        chk("restart_full_hs", qat(fhsf_q, 0), 2 * 656 + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_scanout.md
# pixel_scanout

- Receiving end of the game's pixel-plot interface (x, y, colour, plot).
- Stores 3-bit pixels in a 160x120 on-chip framebuffer and scans it out as 640x480@60 VGA, each stored pixel shown as a 4x4 block.
- Sits between the game FSM and the DE2 VGA DAC pins.
- Also gives the game logic a once-per-frame `frame_start` tick.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `V_VISIBLE`, 480, visible lines per frame
- `SCALE_LOG2`, 2, log2 of upscale factor (160 = 640 >> 2)

Ports:
- `clock`  in  1  system clock, 50 MHz
- `resetn`  in  1  asynchronous, active-high reset; the block is in reset while high
- `x`  in  8  write column, valid 0..159
- `y`  in  7  write row, valid 0..119
- `colour`  in  3  {R,G,B}, 1 bit each
- `plot`  in  1  write strobe, sampled every clock
- `frame_start`  out  1  one-clock pulse at the first clock of vertical front porch
- `clipped`  out  1  one-clock pulse when a write is dropped (see Configuration)
- `VGA_CLK`  out  1  25 MHz pixel clock (`clock`/2)
- `VGA_HS`, `VGA_VS`  out  1  syncs, active-low
- `VGA_BLANK_N`  out  1  high during visible area
- `VGA_SYNC_N`  out  1  constant 0
- `VGA_R`, `VGA_G`, `VGA_B`  out  10  colour bit replicated across all 10 bits

## Operation
**Write side**
- Address = y*160 + x (15 bits).
- When `plot`=1 on a clock edge, `colour` is written to that address in the same cycle.
- Writes are always accepted, with no backpressure.
- Writes are independent of scan state.

**Read side**
- `pix_en` toggles every clock; `VGA_CLK` = registered `pix_en`.
- `hcount` (0..799) advances on `pix_en`=1 and wraps 799 -> 0.
  - At each wrap, `vcount` (0..524) advances, wrapping 524 -> 0.
- Horizontal regions: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical regions: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Read address = (vcount>>2)*160 + (hcount>>2), used only in the visible area.
- RGB outputs are forced to 0 when not visible.

**Collisions and frame tick**
- A write and a read to the same address in the same cycle: the read returns the old data.
- `frame_start` pulses when vcount becomes 480 and hcount is 0.

**Reset**
- Clears `hcount`, `vcount` and `pix_en`.
- Output values during reset: `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK_N`=0, RGB=0, `VGA_CLK`=0, `frame_start`=0, `clipped`=0.
- Framebuffer contents are not cleared.
- Reset asserted mid-frame restarts the scan at (0,0) on the first enabled pixel after release.

## Timing
- Write-to-display latency: one clock into memory; the pixel appears on the next scan of that location.
- Read pipeline:
  - cycle c: counters decode to an address.
  - c+1: memory data valid.
  - c+2: RGB registered.
- HS, VS and BLANK_N pass through the same 2-clock delay, so they stay aligned with RGB.
- All outputs are registered; there is no combinational path from the inputs to the VGA pins.
- Line period is 1600 clocks and frame period is 840000 clocks, so `frame_start` occurs every 840000 clocks.

## Configuration
`PIXEL_SCANOUT_CLIP_EN`
- Defined:
  - A write with x>=160 or y>=120 is dropped.
  - `clipped` pulses high for that clock.
- Undefined:
  - The address is computed from the raw x/y.
  - Writes with address >=19200 are dropped silently.
  - In-range addresses from out-of-range x alias: x=170, y=0 writes pixel (10,1).
  - `clipped` is tied 0.

## Test plan
- **Reset/idle:** assert `resetn` for 5 clocks, then release.
  - During reset: HS=VS=1, BLANK_N=0, RGB=0.
  - After release: first HS falling edge at clock 2*656+2.
- **Sync period:** run 2 frames.
  - HS low for 192 clocks every 1600 clocks.
  - VS low for 3200 clocks every 840000 clocks.
  - `frame_start` pulses exactly twice, 840000 clocks apart.
- **Write then scan:** plot x=0, y=0, colour=3'b110.
  - Next frame, screen pixels (0..3, 0..3) show R=10'h3FF, G=10'h3FF, B=0; pixel (4,0) shows the prior contents.
- **Corner write:** plot x=159, y=119, colour=3'b011.
  - Screen pixels (636..639, 476..479) show R=0, G=B=10'h3FF.
  - Screen pixel (640, 476) is blanked.
- **Clip:** plot x=170, y=0, colour=3'b111.
  - With macro: `clipped`=1 for one clock and pixel (10,1) is unchanged.
  - Without macro: pixel (10,1) becomes 3'b111 and `clipped` stays 0.
- **Mid-frame reset and collision:**
  - Pulse reset at vcount=200: the next VS low starts 490 lines after release.
  - Write colour=3'b001 to the address being read in the same cycle: old data is displayed that frame and new data the next.
